// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI-over-APB sequencer: the SPI core register map,
// the status bit position and the state encodings used by the sequencer and its APB port.
package spi_regs_pkg;

  localparam logic [2:0] REG_CR1 = 3'd0;
  localparam logic [2:0] REG_CR2 = 3'd1;
  localparam logic [2:0] REG_BR  = 3'd2;
  localparam logic [2:0] REG_SR  = 3'd3;
  localparam logic [2:0] REG_DR  = 3'd5;

  localparam int SR_SPIF_BIT = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CR1,
    S_CR2,
    S_BR,
    S_WR_DR,
    S_WAIT,
    S_RD_SR,
    S_RD_DR,
    S_RX_OUT
  } seq_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_t;

endpackage

// File: rtl/apb_master_port.sv
// Single-transfer APB master: a req pulse in A_IDLE launches SETUP then ACCESS,
// and done pulses for one cycle after the slave answers, with read data and error captured.
module apb_master_port
  import spi_regs_pkg::*;
(
  input  logic       Pclk,
  input  logic       Presetn,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic [2:0] PADDR,
  output logic       PWRITE,
  output logic       PSEL,
  output logic       PENABLE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  apb_state_t state;

  // Requests are only honoured in A_IDLE; the cycle carrying done always has PSEL low,
  // which guarantees the idle cycle between consecutive transfers.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state   <= A_IDLE;
      done    <= 1'b0;
      rdata   <= 8'h00;
      slverr  <= 1'b0;
      PADDR   <= 3'd0;
      PWRITE  <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWDATA  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        A_IDLE: begin
          if (req) begin
            PSEL   <= 1'b1;
            PADDR  <= addr;
            PWRITE <= we;
            PWDATA <= wdata;
            state  <= A_SETUP;
          end
        end
        A_SETUP: begin
          PENABLE <= 1'b1;
          state   <= A_ACCESS;
        end
        A_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            done    <= 1'b1;
            rdata   <= PRDATA;
            slverr  <= PSLVERR;
            state   <= A_IDLE;
          end
        end
        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_apb_sequencer.sv
// Streams bytes through the SPI master core over APB: programs CR1/CR2/BR on request,
// then per byte writes DR, waits for SPIF (irq or SR polling), reads DR and presents it.
module spi_apb_sequencer
  import spi_regs_pkg::*;
#(
  parameter logic [2:0] ADDR_CR1 = REG_CR1,
  parameter logic [2:0] ADDR_CR2 = REG_CR2,
  parameter logic [2:0] ADDR_BR  = REG_BR,
  parameter logic [2:0] ADDR_SR  = REG_SR,
  parameter logic [2:0] ADDR_DR  = REG_DR,
  parameter int         SPIF_BIT = SR_SPIF_BIT,
  parameter bit         USE_IRQ  = 1'b1,
  parameter int         POLL_GAP = 4
) (
  input  logic       Pclk,
  input  logic       Presetn,
  input  logic [7:0] cfg_cr1,
  input  logic [7:0] cfg_cr2,
  input  logic [7:0] cfg_br,
  input  logic       cfg_load,
  output logic       cfg_done,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic [2:0] PADDR,
  output logic       PWRITE,
  output logic       PSEL,
  output logic       PENABLE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       spi_irq
);

  localparam logic [7:0] GAP      = 8'(POLL_GAP);
  localparam logic [2:0] SPIF_IDX = 3'(SPIF_BIT);

  seq_state_t state;
  logic [7:0] cr1_q, cr2_q, br_q, cr1_now, poll_cnt;
  logic       cfg_pending, cfg_req, xfer_ok, poll_fire;
  logic       start, start_we, done, slverr;
  logic [2:0] start_addr;
  logic [7:0] start_wdata, rdata;

  assign cfg_req   = cfg_pending | cfg_load;
  assign cr1_now   = cfg_load ? cfg_cr1 : cr1_q;
  assign xfer_ok   = done & ~slverr;
  assign poll_fire = (state == S_WAIT) && (USE_IRQ ? spi_irq : (poll_cnt >= GAP));
  assign tx_ready  = (state == S_IDLE) && cfg_done && !cfg_req;
  assign busy      = (state != S_IDLE);

  // Launch the next APB transfer on the same edge the FSM moves, so a byte accepted in
  // S_IDLE shows PSEL on the very next cycle and a completed transfer chains without delay.
  always_comb begin
    start       = 1'b0;
    start_we    = 1'b1;
    start_addr  = ADDR_CR1;
    start_wdata = cr1_now;
    unique case (state)
      S_IDLE: begin
        if (cfg_req) begin
          start = 1'b1;
        end else if (tx_valid && tx_ready) begin
          start       = 1'b1;
          start_addr  = ADDR_DR;
          start_wdata = tx_data;
        end
      end
      S_CR1, S_CR2, S_BR: begin
        if (xfer_ok) begin
          if (cfg_req) begin
            start = 1'b1;
          end else if (state == S_CR1) begin
            start       = 1'b1;
            start_addr  = ADDR_CR2;
            start_wdata = cr2_q;
          end else if (state == S_CR2) begin
            start       = 1'b1;
            start_addr  = ADDR_BR;
            start_wdata = br_q;
          end
        end
      end
      S_WAIT: begin
        if (poll_fire) begin
          start       = 1'b1;
          start_we    = 1'b0;
          start_addr  = ADDR_SR;
          start_wdata = 8'h00;
        end
      end
      S_RD_SR: begin
        if (xfer_ok && rdata[SPIF_IDX]) begin
          start       = 1'b1;
          start_we    = 1'b0;
          start_addr  = ADDR_DR;
          start_wdata = 8'h00;
        end
      end
      default: ;
    endcase
  end

  // A slave error on any transfer abandons the sequence; a config load arriving
  // mid-programming restarts at CR1 once the current write finishes.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state       <= S_IDLE;
      cr1_q       <= 8'h00;
      cr2_q       <= 8'h00;
      br_q        <= 8'h00;
      cfg_pending <= 1'b0;
      cfg_done    <= 1'b0;
      poll_cnt    <= 8'h00;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      err         <= 1'b0;
    end else begin
      if (cfg_load) begin
        cr1_q       <= cfg_cr1;
        cr2_q       <= cfg_cr2;
        br_q        <= cfg_br;
        cfg_pending <= 1'b1;
      end
      err <= (err & ~err_clr) | (done & slverr);
      if (done && slverr) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cfg_req) begin
              state       <= S_CR1;
              cfg_done    <= 1'b0;
              cfg_pending <= 1'b0;
            end else if (tx_valid && tx_ready) begin
              state <= S_WR_DR;
            end
          end
          S_CR1, S_CR2, S_BR: begin
            if (done) begin
              if (cfg_req) begin
                state       <= S_CR1;
                cfg_pending <= 1'b0;
              end else if (state == S_CR1) begin
                state <= S_CR2;
              end else if (state == S_CR2) begin
                state <= S_BR;
              end else begin
                state    <= S_IDLE;
                cfg_done <= 1'b1;
              end
            end
          end
          S_WR_DR: begin
            if (done) begin
              state    <= S_WAIT;
              poll_cnt <= 8'h00;
            end
          end
          S_WAIT: begin
            if (poll_fire) begin
              state <= S_RD_SR;
            end else if (poll_cnt < GAP) begin
              poll_cnt <= poll_cnt + 8'd1;
            end
          end
          S_RD_SR: begin
            if (done) begin
              if (rdata[SPIF_IDX]) begin
                state <= S_RD_DR;
              end else begin
                state    <= S_WAIT;
                poll_cnt <= 8'h00;
              end
            end
          end
          S_RD_DR: begin
            if (done) begin
              rx_data  <= rdata;
              rx_valid <= 1'b1;
              state    <= S_RX_OUT;
            end
          end
          S_RX_OUT: begin
            if (rx_ready) begin
              rx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  apb_master_port u_apb (
    .Pclk    (Pclk),
    .Presetn (Presetn),
    .req     (start),
    .we      (start_we),
    .addr    (start_addr),
    .wdata   (start_wdata),
    .done    (done),
    .rdata   (rdata),
    .slverr  (slverr),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// Bench for spi_apb_sequencer (SR polling mode): an APB slave with random wait states logs every
// transfer, which is compared with the register-level sequence expected for each request.
module tb_spi_apb_sequencer;

  localparam int POLL_GAP = 4;

  logic       Pclk = 1'b0;
  logic       Presetn = 1'b0;
  logic [7:0] cfg_cr1 = 8'h00, cfg_cr2 = 8'h00, cfg_br = 8'h00;
  logic       cfg_load = 1'b0, cfg_done;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       busy, err, err_clr = 1'b0;
  logic [2:0] PADDR;
  logic       PWRITE, PSEL, PENABLE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'h00;
  logic       PREADY = 1'b0, PSLVERR = 1'b0;
  logic       spi_irq = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Transfer log entries are {write, address, data}
  logic [11:0] exp_q[$];
  logic [11:0] act_q[$];

  int         min_ws = 0, max_ws = 0, sr_polls = 0, wait_left = 0, idle_cnt = 0;
  logic [7:0] rx_byte = 8'h00, slv_data;
  bit         inject_err = 1'b0, last_done = 1'b0, last_was_sr = 1'b0;
  logic [11:0] setup_bus = 12'h000;

  spi_apb_sequencer #(
    .USE_IRQ  (1'b0),
    .POLL_GAP (POLL_GAP)
  ) dut (
    .Pclk     (Pclk),
    .Presetn  (Presetn),
    .cfg_cr1  (cfg_cr1),
    .cfg_cr2  (cfg_cr2),
    .cfg_br   (cfg_br),
    .cfg_load (cfg_load),
    .cfg_done (cfg_done),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .spi_irq  (spi_irq)
  );

  always #5 Pclk = ~Pclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void expPush(input bit we, input logic [2:0] addr, input logic [7:0] data);
    exp_q.push_back({we, addr, data});
  endfunction

  task automatic checkLog(input string tag);
    checkOutput({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      checkOutput($sformatf("%s_%0d", tag, i), act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  // APB slave: SR reads report busy sr_polls times then SPIF; DR reads return rx_byte.
  always @(negedge Pclk) begin
    if (!Presetn) begin
      PREADY = 1'b0; PSLVERR = 1'b0; wait_left = 0;
      last_done = 1'b0; last_was_sr = 1'b0; idle_cnt = 0;
    end else begin
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      if (last_done) checkOutput("apb_idle_gap", PSEL, 0);
      last_done = 1'b0;
      if (!PSEL) begin
        idle_cnt++;
      end else if (!PENABLE) begin
        setup_bus = {PWRITE, PADDR, PWDATA};
        wait_left = $urandom_range(max_ws, min_ws);
        if (!PWRITE && PADDR == 3'd3 && last_was_sr)
          checkOutput("sr_poll_gap", idle_cnt >= POLL_GAP, 1);
        idle_cnt = 0;
      end else begin
        checkOutput("apb_stable", {PWRITE, PADDR, PWDATA}, setup_bus);
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          PREADY = 1'b1;
          if (PWRITE) begin
            PSLVERR = inject_err && PADDR == 3'd5;
            if (PSLVERR) inject_err = 1'b0;
            slv_data = PWDATA;
          end else begin
            if (PADDR == 3'd3) begin
              if (sr_polls > 0) begin
                slv_data = 8'h00;
                sr_polls--;
              end else begin
                slv_data = 8'h80;
              end
            end else if (PADDR == 3'd5) begin
              slv_data = rx_byte;
            end else begin
              slv_data = 8'h00;
            end
            PRDATA = slv_data;
          end
          act_q.push_back({PWRITE, PADDR, slv_data});
          last_done = 1'b1;
          last_was_sr = !PWRITE && PADDR == 3'd3;
        end
      end
    end
  end

  task automatic applyConfig(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    bit ok;
    @(negedge Pclk);
    cfg_cr1 = c1; cfg_cr2 = c2; cfg_br = c3; cfg_load = 1'b1;
    @(negedge Pclk);
    cfg_load = 1'b0;
    checkOutput("cfg_done_drop", cfg_done, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Pclk);
      if (cfg_done) begin ok = 1'b1; break; end
    end
    checkOutput("cfg_done_rise", ok, 1);
    expPush(1'b1, 3'd0, c1);
    expPush(1'b1, 3'd1, c2);
    expPush(1'b1, 3'd2, c3);
    checkLog("cfg");
  endtask

  task automatic offerByte(input logic [7:0] tx);
    bit ok;
    @(negedge Pclk);
    tx_valid = 1'b1;
    tx_data = tx;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_ready) begin ok = 1'b1; break; end
      @(negedge Pclk);
    end
    checkOutput("tx_accept", ok, 1);
    @(posedge Pclk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic waitRx(input logic [7:0] rxb);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Pclk);
      if (rx_valid) begin ok = 1'b1; break; end
    end
    checkOutput("rx_valid_rise", ok, 1);
    checkOutput("rx_data", rx_data, rxb);
  endtask

  task automatic consumeRx();
    rx_ready = 1'b1;
    @(negedge Pclk);
    rx_ready = 1'b0;
    checkOutput("rx_valid_clear", {rx_valid, busy}, 0);
  endtask

  // One byte: expected log is DR write, polls+1 SR reads, DR read (or only the failing DR write).
  task automatic applyStimulus(input logic [7:0] tx, input int polls, input logic [7:0] rxb,
                               input bit inject, input int hold);
    bit ok;
    sr_polls = polls;
    rx_byte = rxb;
    inject_err = inject;
    offerByte(tx);
    @(negedge Pclk);
    checkOutput("tx_to_psel", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, 1'b1, 3'd5, tx});
    expPush(1'b1, 3'd5, tx);
    if (inject) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge Pclk);
        if (!busy) begin ok = 1'b1; break; end
      end
      checkOutput("err_abort_idle", ok, 1);
      checkOutput("err_flag", {err, rx_valid}, 2'b10);
      checkLog("err_seq");
    end else begin
      for (int i = 0; i < polls; i++) expPush(1'b0, 3'd3, 8'h00);
      expPush(1'b0, 3'd3, 8'h80);
      expPush(1'b0, 3'd5, rxb);
      waitRx(rxb);
      checkLog("byte");
      tx_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge Pclk);
        checkOutput("rx_hold", {rx_valid, rx_data, tx_ready, PSEL}, {1'b1, rxb, 1'b0, 1'b0});
      end
      tx_valid = 1'b0;
      checkOutput("rx_hold_no_apb", act_q.size(), 0);
      consumeRx();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    repeat (2) @(negedge Pclk);
    checkOutput("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    checkOutput("reset_out", {tx_ready, rx_valid, rx_data, cfg_done, busy, err}, 0);
    Presetn = 1'b1;
    tx_valid = 1'b1;
    @(negedge Pclk);
    checkOutput("no_tx_before_cfg", {tx_ready, busy, PSEL}, 0);
    tx_valid = 1'b0;

    $display("[TB] config and first byte");
    applyConfig(8'h50, 8'h00, 8'h12);
    applyStimulus(8'hA5, 2, 8'h3C, 1'b0, 10);

    $display("[TB] randomized bytes");
    for (int n = 0; n < 24; n++) begin
      max_ws = $urandom_range(3, 0);
      if (n % 8 == 7) applyConfig(8'($urandom), 8'($urandom), 8'($urandom));
      applyStimulus(8'($urandom), $urandom_range(3, 0), 8'($urandom), 1'b0, $urandom_range(3, 0));
    end

    $display("[TB] slave error on DR write");
    max_ws = 1;
    applyStimulus(8'h5A, 0, 8'h00, 1'b1, 0);
    @(negedge Pclk);
    err_clr = 1'b1;
    @(negedge Pclk);
    err_clr = 1'b0;
    checkOutput("err_cleared", err, 0);
    applyStimulus(8'h81, 1, 8'h7E, 1'b0, 0);

    $display("[TB] config load during wait");
    sr_polls = 3;
    rx_byte = 8'hC7;
    offerByte(8'h3E);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Pclk);
      if (act_q.size() >= 1) begin ok = 1'b1; break; end
    end
    checkOutput("dr_write_seen", ok, 1);
    repeat (3) @(negedge Pclk);
    cfg_cr1 = 8'h5C; cfg_cr2 = 8'h01; cfg_br = 8'h07; cfg_load = 1'b1;
    @(negedge Pclk);
    cfg_load = 1'b0;
    checkOutput("cfg_hold_inflight", {cfg_done, busy}, 2'b11);
    waitRx(8'hC7);
    consumeRx();
    @(negedge Pclk);
    checkOutput("cfg_drop_rewrite", {cfg_done, busy}, 2'b01);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Pclk);
      if (cfg_done) begin ok = 1'b1; break; end
    end
    checkOutput("cfg_rewrite_done", ok, 1);
    expPush(1'b1, 3'd5, 8'h3E);
    for (int i = 0; i < 3; i++) expPush(1'b0, 3'd3, 8'h00);
    expPush(1'b0, 3'd3, 8'h80);
    expPush(1'b0, 3'd5, 8'hC7);
    expPush(1'b1, 3'd0, 8'h5C);
    expPush(1'b1, 3'd1, 8'h01);
    expPush(1'b1, 3'd2, 8'h07);
    checkLog("cfg_during_wait");

    $display("[TB] reset during access");
    min_ws = 3; max_ws = 3;
    sr_polls = 0;
    offerByte(8'h99);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Pclk);
      #2;
      if (PSEL && PENABLE) begin ok = 1'b1; break; end
    end
    checkOutput("rst_reach_access", ok, 1);
    checkOutput("rst_pready_low", PREADY, 0);
    Presetn = 1'b0;
    #1;
    checkOutput("rst_async_apb", {PSEL, PENABLE}, 0);
    repeat (2) @(negedge Pclk);
    Presetn = 1'b1;
    act_q.delete();
    exp_q.delete();
    min_ws = 0; max_ws = 2;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Pclk);
      checkOutput("post_rst_idle", {tx_ready, cfg_done, PSEL, busy, rx_valid}, 0);
    end
    tx_valid = 1'b0;
    applyConfig(8'h44, 8'h02, 8'h03);
    applyStimulus(8'h0F, 1, 8'hF0, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
